// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//   Sequences the VRAM write port (data_address/data_din/data_we). Two valid/ready
//   requesters share the port round-robin. A full-screen clear engine takes priority
//   over both requesters while it runs.
//
//   Optional feature macro: VSYNC_GATE_EN
//     defined   - an accepted clear_start parks in WAIT_VS until a vsync falling edge,
//                 and the clear starts on the following cycle.
//     undefined - the clear begins the cycle after clear_start, and vsync is ignored.
//
// Ports
//   clk, reset        clock, synchronous active-low reset
//   req0_* / req1_*   requester valid/ready handshakes with address and pixel
//                     (ready is combinational)
//   clear_start       single-cycle pulse that fills the whole VRAM with clear_color
//   clear_color       fill pixel, captured when clear_start is accepted
//   clear_busy        high while a clear is pending or running (registered)
//   vsync             synchronized active-low VGA vsync
//   data_address      registered write address, zero-extended to 32 bits
//   data_din          registered write data
//   data_we           registered write enable
module vram_write_scheduler #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    input  logic                  clear_start,
    input  logic [DATA_WIDTH-1:0] clear_color,
    output logic                  clear_busy,
    input  logic                  vsync,
    output logic [31:0]           data_address,
    output logic [DATA_WIDTH-1:0] data_din,
    output logic                  data_we
);

    localparam int unsigned OUT_ADDR_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_CLEAR   = 2'd1
`ifdef VSYNC_GATE_EN
        ,
        ST_WAIT_VS = 2'd2
`endif
    } state_t;

    state_t                  state, state_next;
    logic                    rr, rr_next;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_next;
    logic [DATA_WIDTH-1:0]   color;
    logic                    color_load_c;
    logic                    ready0_c, ready1_c;
    logic                    issue_c;
    logic [OUT_ADDR_WIDTH-1:0] issue_addr_c;
    logic [DATA_WIDTH-1:0]   issue_data_c;

`ifdef VSYNC_GATE_EN
    logic vs_q;
    logic vs_fall_c;

    // Registered vsync for falling-edge detection; idles high like the sync pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vs_q <= 1'b1;
        end else begin
            vs_q <= vsync;
        end
    end

    assign vs_fall_c = vs_q & ~vsync;
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
`endif

    // State, arbitration pointer, clear counter and latched fill colour.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_ARB;
            rr    <= 1'b0;
            cnt   <= '0;
            color <= '0;
        end else begin
            state <= state_next;
            rr    <= rr_next;
            cnt   <= cnt_next;
            if (color_load_c) begin
                color <= clear_color;
            end
        end
    end

    // Next-state logic, grant selection and the write to issue this cycle.
    always_comb begin
        state_next   = state;
        rr_next      = rr;
        cnt_next     = cnt;
        color_load_c = 1'b0;
        ready0_c     = 1'b0;
        ready1_c     = 1'b0;
        issue_c      = 1'b0;
        issue_addr_c = '0;
        issue_data_c = '0;

        case (state)
            ST_ARB: begin
                if (clear_start) begin
                    color_load_c = 1'b1;
`ifdef VSYNC_GATE_EN
                    state_next   = ST_WAIT_VS;
`else
                    state_next   = ST_CLEAR;
`endif
                end else if (req0_valid && (!req1_valid || !rr)) begin
                    ready0_c     = 1'b1;
                    rr_next      = 1'b1;
                    issue_c      = 1'b1;
                    issue_addr_c = OUT_ADDR_WIDTH'(req0_addr);
                    issue_data_c = req0_data;
                end else if (req1_valid) begin
                    ready1_c     = 1'b1;
                    rr_next      = 1'b0;
                    issue_c      = 1'b1;
                    issue_addr_c = OUT_ADDR_WIDTH'(req1_addr);
                    issue_data_c = req1_data;
                end
            end
`ifdef VSYNC_GATE_EN
            ST_WAIT_VS: begin
                if (vs_fall_c) begin
                    state_next = ST_CLEAR;
                end
            end
`endif
            ST_CLEAR: begin
                issue_c      = 1'b1;
                issue_addr_c = OUT_ADDR_WIDTH'(cnt);
                issue_data_c = color;
                if (cnt == CNT_MAX) begin
                    state_next = ST_ARB;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_next = ST_ARB;
                cnt_next   = '0;
            end
        endcase
    end

    // Ready is suppressed while reset is held, whatever state the flops are in.
    assign req0_ready = ready0_c & reset;
    assign req1_ready = ready1_c & reset;

    // Registered write port. Address and data hold when no write is issued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_we      <= 1'b0;
            data_address <= '0;
            data_din     <= '0;
            clear_busy   <= 1'b0;
        end else begin
            data_we    <= issue_c;
            clear_busy <= (state_next != ST_ARB);
            if (issue_c) begin
                data_address <= issue_addr_c;
                data_din     <= issue_data_c;
            end
        end
    end

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: reset, single write, round-robin
// contention, full clear with priority over a waiting requester, and reset abort.
module tb_vram_write_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [11:0] req0_addr;
    logic [7:0]  req0_data;
    logic        req1_valid, req1_ready;
    logic [11:0] req1_addr;
    logic [7:0]  req1_data;
    logic        clear_start;
    logic [7:0]  clear_color;
    logic        clear_busy;
    logic        vsync;
    logic [31:0] data_address;
    logic [7:0]  data_din;
    logic        data_we;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vram_write_scheduler #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .clear_start  (clear_start),
        .clear_color  (clear_color),
        .clear_busy   (clear_busy),
        .vsync        (vsync),
        .data_address (data_address),
        .data_din     (data_din),
        .data_we      (data_we)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue clear_start in the current cycle. With vsync gating, also wait in
    // WAIT_VS and then drop vsync, so the caller's timing is relative to the
    // cycle in which the clear becomes committed.
    task automatic start_clear(input logic [7:0] color);
        clear_start = 1'b1;
        clear_color = color;
        #1;
        check("clr_start_ready0", req0_ready, 0);
        check("clr_start_ready1", req1_ready, 0);
`ifdef VSYNC_GATE_EN
        tick();
        clear_start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            check("gate_busy", clear_busy, 1);
            check("gate_no_we", data_we, (w == 0) ? 0 : 0);
            #1;
            check("gate_ready1", req1_ready, 0);
            tick();
        end
        check("gate_no_we_last", data_we, 0);
        vsync = 1'b0;
        #1;
`endif
    endtask

    initial begin
        int bad_wr, bad_busy, bad_rdy, we_cnt;

        reset = 1'b0;
        req0_valid = 1'b1; req0_addr = 12'h0; req0_data = 8'h0;
        req1_valid = 1'b1; req1_addr = 12'h0; req1_data = 8'h0;
        clear_start = 1'b0; clear_color = 8'h0; vsync = 1'b1;

        // 1: reset held with both requesters valid
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_we", data_we, 0);
            check("rst_busy", clear_busy, 0);
            #1;
            check("rst_ready0", req0_ready, 0);
            check("rst_ready1", req1_ready, 0);
        end
        check("rst_addr", data_address, 0);
        check("rst_din", data_din, 0);

        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // 2: single requester write and registered output latency
        req0_valid = 1'b1; req0_addr = 12'h123; req0_data = 8'hE0;
        #1;
        check("single_ready0", req0_ready, 1);
        check("single_ready1", req1_ready, 0);
        tick();
        check("single_we", data_we, 1);
        check("single_addr", data_address, 32'h123);
        check("single_din", data_din, 8'hE0);
        req0_valid = 1'b0;
        tick();
        check("idle_we", data_we, 0);
        check("idle_addr_hold", data_address, 32'h123);
        check("idle_din_hold", data_din, 8'hE0);

        // Reset pulse returns the round-robin pointer to requester 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // 3: contention alternates grants 0,1,0,1 with back-to-back writes
        req0_valid = 1'b1; req0_addr = 12'h010; req0_data = 8'h11;
        req1_valid = 1'b1; req1_addr = 12'h020; req1_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
            check("cont_ready1", req1_ready, (i % 2 == 0) ? 0 : 1);
            tick();
            check("cont_we", data_we, 1);
            check("cont_addr", data_address, (i % 2 == 0) ? 32'h010 : 32'h020);
            check("cont_din", data_din, (i % 2 == 0) ? 8'h11 : 8'h22);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // 4+5: clear with requester 1 waiting; clear_start while busy is ignored
        req1_valid = 1'b1; req1_addr = 12'h777; req1_data = 8'h55;
        start_clear(8'h1C);
        bad_wr = 0; bad_busy = 0; bad_rdy = 0; we_cnt = 0;
        for (int n = 1; n <= 4098; n++) begin
            tick();
            if (n >= 2 && n <= 4097) begin
                if (data_we !== 1'b1 || data_address !== 32'(n - 2) || data_din !== 8'h1C)
                    bad_wr++;
                if (data_we === 1'b1) we_cnt++;
            end
            if (clear_busy !== ((n <= 4096) ? 1'b1 : 1'b0)) bad_busy++;
            if (n == 1) begin
                check("clr_first_busy", clear_busy, 1);
                check("clr_first_no_we", data_we, 0);
            end
            if (n == 2) check("clr_addr0", data_address, 0);
            if (n == 4096) check("clr_last_busy", clear_busy, 1);
            if (n == 4097) begin
                check("clr_end_busy", clear_busy, 0);
                check("clr_addr_max", data_address, 32'hFFF);
                check("clr_din_max", data_din, 8'h1C);
            end
            if (n == 4098) begin
                check("post_clr_we", data_we, 1);
                check("post_clr_addr", data_address, 32'h777);
                check("post_clr_din", data_din, 8'h55);
            end
            clear_start = (n == 50);
            clear_color = (n == 50) ? 8'h03 : 8'hFF;
            vsync = 1'b1;
            if (n == 4098) req1_valid = 1'b0;
            #1;
            if (n <= 4096 && req1_ready !== 1'b0) bad_rdy++;
            if (n == 4097) check("post_clr_ready1", req1_ready, 1);
        end
        check("clr_write_seq", bad_wr, 0);
        check("clr_write_count", we_cnt, 4096);
        check("clr_busy_seq", bad_busy, 0);
        check("clr_ready_blocked", bad_rdy, 0);
        clear_start = 1'b0;
        tick();

        // 6: reset asserted while the clear is writing address 100
        start_clear(8'hA5);
        for (int n = 1; n <= 102; n++) begin
            tick();
            clear_start = 1'b0;
            vsync = 1'b1;
        end
        check("abort_pre_we", data_we, 1);
        check("abort_pre_addr", data_address, 32'd100);
        check("abort_pre_din", data_din, 8'hA5);
        reset = 1'b0;
        req0_valid = 1'b1;
        #1;
        check("abort_ready0", req0_ready, 0);
        tick();
        check("abort_we", data_we, 0);
        check("abort_busy", clear_busy, 0);
        check("abort_addr", data_address, 0);
        reset = 1'b1;
        req0_valid = 1'b0;
        tick();
        tick();
        check("abort_after_we", data_we, 0);
        check("abort_after_busy", clear_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
